// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register bank:
// mode encodings and the counter-width helper.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Width of a counter that must reach WIDTH-1 before wrapping.
    function automatic int unsigned usr_cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the shift bank: 4:1 next-state mux feeding a flip-flop
// with synchronous active-low reset and clock enable.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       shr_in_i,
    input  logic       shl_in_i,
    input  logic       load_i,
    input  logic       rst_val_i,
    output logic       q_o
);

    logic q_q;
    logic q_d;

    // Select the next value of this bit from the operating mode.
    always_comb begin
        q_d = q_q;
        case (mode_i)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = shr_in_i;
            MODE_SHL:  q_d = shl_in_i;
            MODE_LOAD: q_d = load_i;
            default:   q_d = q_q;
        endcase
    end

    // Bit storage; reset wins over enable.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            q_q <= rst_val_i;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/usr_shift_bank.sv
// Parametrised universal shift register (hold / shift right / shift left /
// parallel load) with a shift counter that pulses `done` after every WIDTH
// shifts. Optional build macro USR_ROTATE_EN adds a `rot` input that turns
// shifts into rotates (serial inputs ignored).
module usr_shift_bank
    import usr_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    localparam int unsigned      CW      = usr_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             done,
    output logic [CW-1:0]    cnt
);

    logic [WIDTH-1:0] q_w;
    logic             ser_r;
    logic             ser_l;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             done_q;
    logic             done_d;

    // Serial bits entering at the ends; in rotate mode they wrap around.
`ifdef USR_ROTATE_EN
    assign ser_r = rot ? q_w[0]       : sin_r;
    assign ser_l = rot ? q_w[WIDTH-1] : sin_l;
`else
    assign ser_r = sin_r;
    assign ser_l = sin_l;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic upper;
        logic lower;

        if (i == WIDTH - 1) begin : g_top
            assign upper = ser_r;
        end else begin : g_mid_hi
            assign upper = q_w[i+1];
        end

        if (i == 0) begin : g_bot
            assign lower = ser_l;
        end else begin : g_mid_lo
            assign lower = q_w[i-1];
        end

        usr_bit_cell u_cell (
            .clk_i     (clk),
            .reset_ni  (reset),
            .en_i      (en),
            .mode_i    (mode),
            .shr_in_i  (upper),
            .shl_in_i  (lower),
            .load_i    (d[i]),
            .rst_val_i (RST_VAL[i]),
            .q_o       (q_w[i])
        );
    end

    // Shift counter next state: counts both directions, wraps at WIDTH-1
    // and raises done on the wrapping edge; a load clears it.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR, MODE_SHL: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                MODE_LOAD: cnt_d = '0;
                default:   cnt_d = cnt_q;
            endcase
        end
    end

    // Counter and done registers; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q      = q_w;
    assign sout_r = q_w[0];
    assign sout_l = q_w[WIDTH-1];
    assign done   = done_q;
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_usr_shift_bank.sv
// Self-checking bench for usr_shift_bank (WIDTH = 4, RST_VAL = 0):
// directed scenarios plus randomized operations against an arithmetic model.
module tb_usr_shift_bank;

    localparam int unsigned W    = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic         rot;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic         done;
    logic [1:0]   cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_q      = 0;
    int unsigned m_shifts = 0;
    bit          m_done   = 1'b0;

    always #5 clk = ~clk;

    usr_shift_bank #(
        .WIDTH   (W),
        .RST_VAL (4'h0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
`ifdef USR_ROTATE_EN
        .rot    (rot),
`endif
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .done   (done),
        .cnt    (cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one operation, advance one edge, update the model, compare.
    task automatic cycle(input bit r, input bit e, input bit [1:0] md, input bit [3:0] dd,
                         input bit sr, input bit sl, input bit rt);
        int unsigned bit_in;
        reset = r; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl; rot = rt;
        @(posedge clk);
        if (!r) begin
            m_q = 0; m_shifts = 0; m_done = 1'b0;
        end else if (!e || md == 2'b00) begin
            m_done = 1'b0;
        end else if (md == 2'b11) begin
            m_q = dd; m_shifts = 0; m_done = 1'b0;
        end else begin
            if (md == 2'b01) begin
                bit_in = rt ? (m_q & 1) : int'(sr);
                m_q    = (m_q >> 1) | (bit_in << (W - 1));
            end else begin
                bit_in = rt ? ((m_q >> (W - 1)) & 1) : int'(sl);
                m_q    = ((m_q << 1) | bit_in) & MASK;
            end
            m_shifts++;
            m_done = (m_shifts == W);
            if (m_done) m_shifts = 0;
        end
        #1;
        check("q",      32'(q),      m_q);
        check("cnt",    32'(cnt),    m_shifts);
        check("done",   32'(done),   32'(m_done));
        check("sout_r", 32'(sout_r), m_q & 1);
        check("sout_l", 32'(sout_l), (m_q >> (W - 1)) & 1);
    endtask

    initial begin
        int exp_sr[4]  = '{1, 1, 0, 1};
        int exp_cnt[4] = '{1, 2, 3, 0};
        int sl_seq[4]  = '{1, 0, 1, 1};
        int done_seen;
        bit          rr, ee, sr, sl, rt;
        bit [1:0]    md;
        bit [3:0]    dd;

        reset = 1'b0; en = 1'b0; mode = 2'b00; d = '0;
        sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;

        // Reset with load pending
        cycle(0, 1, 2'b11, 4'hF, 0, 0, 0);
        cycle(0, 1, 2'b11, 4'hF, 0, 0, 0);
        check("rst_q", 32'(q), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_done", 32'(done), 0);

        // Load A, then reset toggled between edges has no effect
        cycle(1, 1, 2'b11, 4'hA, 0, 0, 0);
        check("load_a", 32'(q), 32'hA);
        reset = 1'b0;
        #2;
        check("rst_between_edges", 32'(q), 32'hA);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 2'b10, 4'h3, 1, 1, 0);
        check("en0_hold_q", 32'(q), 32'hA);
        check("en0_hold_cnt", 32'(cnt), 0);
        for (int i = 0; i < 2; i++) cycle(1, 1, 2'b00, 4'h3, 1, 1, 0);
        check("mode_hold_q", 32'(q), 32'hA);

        // Right serialise of B
        cycle(1, 1, 2'b11, 4'hB, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("ser_sout_r", 32'(sout_r), 32'(exp_sr[i]));
            cycle(1, 1, 2'b01, 4'h0, 0, 0, 0);
            check("ser_cnt", 32'(cnt), 32'(exp_cnt[i]));
            check("ser_done", 32'(done), (i == 3) ? 1 : 0);
        end
        check("ser_q_end", 32'(q), 0);
        cycle(1, 1, 2'b00, 4'h0, 0, 0, 0);
        check("ser_done_drop", 32'(done), 0);

        // Left deserialise into B, then the next pulse 4 shifts later
        cycle(1, 1, 2'b11, 4'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 2'b10, 4'h0, 0, sl_seq[i][0], 0);
        check("deser_q", 32'(q), 32'hB);
        check("deser_done", 32'(done), 1);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, (i % 2 == 0) ? 2'b10 : 2'b01, 4'h0, 1, 0, 0);
            if (done) done_seen = i + 1;
        end
        check("deser_next_pulse", 32'(done_seen), 4);

        // Reset after two shifts discards the count
        cycle(1, 1, 2'b11, 4'h5, 0, 0, 0);
        cycle(1, 1, 2'b01, 4'h0, 0, 0, 0);
        cycle(1, 1, 2'b01, 4'h0, 0, 0, 0);
        cycle(0, 1, 2'b01, 4'h0, 0, 0, 0);
        check("mid_rst_cnt", 32'(cnt), 0);
        check("mid_rst_done", 32'(done), 0);

        // Load after three shifts restarts the count
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'b10, 4'h0, 0, 1, 0);
        cycle(1, 1, 2'b11, 4'h6, 0, 0, 0);
        check("mid_load_cnt", 32'(cnt), 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 2'b01, 4'h0, 1, 0, 0);
            if (done) done_seen = i + 1;
        end
        check("mid_load_pulse_at", 32'(done_seen), 4);

`ifdef USR_ROTATE_EN
        // Rotate right of 9: C, 6, 3, 9 with done on the last
        cycle(1, 1, 2'b11, 4'h9, 0, 0, 0);
        cycle(1, 1, 2'b01, 4'h0, 1, 1, 1);
        check("rot_q1", 32'(q), 32'hC);
        cycle(1, 1, 2'b01, 4'h0, 1, 1, 1);
        check("rot_q2", 32'(q), 32'h6);
        cycle(1, 1, 2'b01, 4'h0, 1, 1, 1);
        check("rot_q3", 32'(q), 32'h3);
        cycle(1, 1, 2'b01, 4'h0, 1, 1, 1);
        check("rot_q4", 32'(q), 32'h9);
        check("rot_done", 32'(done), 1);
        cycle(1, 1, 2'b01, 4'h0, 0, 0, 0);
        check("rot_off_q", 32'(q), 32'h4);
`endif

        // Randomized operations
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(31) != 0);
            ee = ($urandom_range(7) != 0);
            md = 2'($urandom_range(3));
            if (md == 2'b11 && $urandom_range(3) != 0) md = 2'($urandom_range(1, 2));
            dd = 4'($urandom_range(15));
            sr = 1'($urandom_range(1));
            sl = 1'($urandom_range(1));
`ifdef USR_ROTATE_EN
            rt = 1'($urandom_range(1));
`else
            rt = 1'b0;
`endif
            cycle(rr, ee, md, dd, sr, sl, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_shift_bank.md
Name: usr_shift_bank

Overview:
- Parametrised universal shift register; successor to the single-bit D flip-flop stage.
- WIDTH-bit register with four modes: hold, shift right, shift left, parallel load.
- Shift counter raises a one-cycle `done` pulse after every WIDTH shifts, so the block can serialise or deserialise a whole word.
- Serialiser/deserialiser and delay-line building block for lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RST_VAL, 0, WIDTH-bit value loaded into `q` on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  clock enable; 0 = hold everything, including the counter.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input, enters at MSB on a right shift.
- sin_l  input  1  serial input, enters at LSB on a left shift.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0], combinational from the register.
- sout_l  output  1  q[WIDTH-1], combinational from the register.
- done  output  1  registered one-cycle pulse on completion of the WIDTH-th shift since the last load or reset.
- cnt  output  CW  shifts performed since the last load, wrap or reset; CW = $clog2(WIDTH).

Behaviour:
- One clock; reset is synchronous and active-low. Port `reset` is sampled only at the rising edge of `clk`.
- Reset takes effect when `reset` == 0 at a rising edge:
  - q <= RST_VAL, cnt <= 0, done <= 0.
  - Reset overrides `en` and `mode`.
  - Reset mid-shift discards the partial count; no `done` is produced.
- Priority at each edge: reset, then en == 0, then mode.
- en == 0: q and cnt hold; done <= 0.
- mode 00 (hold): q and cnt hold; done <= 0.
- mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
- mode 11 (load): q <= d, cnt <= 0, done <= 0.
- Counter on a shift (mode 01 or 10 with en == 1):
  - If cnt == WIDTH-1: cnt <= 0 and done <= 1 in the same edge.
  - Otherwise cnt <= cnt+1 and done <= 0.
- `done` is high for exactly the cycle after the WIDTH-th shift edge.
- Shift direction may change between cycles; right and left shifts both count.
- Latency: q, cnt and done reflect an operation one edge after it is sampled. sout_r and sout_l follow q with zero latency.
- Continuous shifting gives a `done` pulse every WIDTH cycles with no gap cycle.
- A load in the cycle after `done` is legal.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: adds input port `rot` (1 bit). When rot == 1 on a shift:
  - shift right gives q <= {q[0], q[WIDTH-1:1]}.
  - shift left gives q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - sin_r and sin_l are ignored.
  - The counter and `done` behave exactly as for a normal shift.
- Not defined: no `rot` port; shifts always take sin_r or sin_l.

Decomposition:
- Shared package `usr_pkg`:
  - mode localparams MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11.
  - a count-width helper function.
- One sub-module `usr_bit_cell`:
  - 4:1 next-state mux plus one flip-flop with synchronous active-low reset and enable.
  - instantiated WIDTH times in a generate loop.
- The counter and `done` logic live in the top level.

Test Plan (all scenarios use WIDTH = 4, RST_VAL = 0):
- Reset: assert reset = 0 for 2 edges with mode = 11 and d = 4'hF -> q = 0, cnt = 0, done = 0. Changing reset between edges has no effect until the next edge.
- Load and hold: load d = 4'hA, then apply en = 0 for 3 cycles -> q stays 4'hA and cnt stays 0. Then mode = 00 for 2 cycles -> unchanged.
- Right serialise: load 4'hB, then shift right with sin_r = 0 for 4 cycles:
  - sout_r sequence is 1, 1, 0, 1.
  - q ends at 4'h0.
  - done is high only in the cycle after the 4th shift.
  - cnt sequence is 1, 2, 3, 0.
- Left deserialise: after load 4'h0, shift left with sin_l = 1, 0, 1, 1 -> q = 4'hB and done pulses once. Continued shifting gives the next pulse exactly 4 cycles later.
- Mid-operation events:
  - Reset after 2 shifts -> cnt = 0 and no done pulse.
  - Load after 3 shifts -> cnt = 0. The next 3 shifts give no done; the 4th shift gives done.
- USR_ROTATE_EN build: load 4'h9, then rot = 1 and shift right 4 times -> q goes 4'hC, 4'h6, 4'h3, 4'h9 and done pulses after the 4th shift. With rot = 0, sin_r is used as normal.
